conv3x3_prog: RTL
=================

Name: conv3x3_prog

Overview:
- Parametrised 3x3 convolution engine; successor to the fixed box-blur convolution stage.
- Sits between the 3-line buffer window (9 pixels/cycle) and the output pixel sink.
- Adds signed, runtime-loadable coefficients (double-buffered), power-of-two normalisation, clamp/absolute output modes, pixel width generalisation and a synchronous reset.
- Fully pipelined: 1 pixel/cycle, no backpressure.

Parameters:
- PIX_W, 8, unsigned pixel width (input and output).
- COEF_W, 8, signed two's-complement coefficient width.
- SHIFT_W, 4, width of normalisation shift field (shift range 0..2^SHIFT_W-1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- pixel_data  in  9*PIX_W  window; tap i at [i*PIX_W +: PIX_W], i = row*3+col, row 0 = oldest line, col 0 = oldest column
- pixel_data_valid  in  1  window valid
- coef_we  in  1  write one shadow coefficient
- coef_addr  in  4  tap index 0..8; 9..15 ignored
- coef_data  in  COEF_W  signed coefficient
- cfg_shift  in  SHIFT_W  shadow normalisation shift, sampled on coef_commit
- cfg_abs  in  1  shadow mode (0 = clamp, 1 = absolute value), sampled on coef_commit
- coef_commit  in  1  copy shadow bank to active bank
- conv_data  out  PIX_W  result pixel
- conv_data_valid  out  1  result valid
- sat_flag  out  1  result was clamped at this output beat

Behaviour:
- Reset (rst=1 at clk edge): active and shadow kernels = identity (tap 4 = 1, others 0); active shift = 0; active abs = 0; all pipeline valid bits, conv_data, conv_data_valid and sat_flag = 0. Data registers are reset too. Reset mid-stream drops all in-flight beats; no valid is asserted until 4 cycles after the first post-reset input valid.
- Coefficient load: coef_we writes coef_data into shadow[coef_addr]. coef_commit copies all 9 shadow taps, cfg_shift and cfg_abs into the active set on the same edge.
  - coef_we together with coef_commit: the same-cycle write is included in the commit (bypass).
  - Commit takes effect for windows accepted on the cycle after the commit edge. Beats already past stage 1 finish with the old kernel, shift and mode; each carries its shift/abs with it down the pipe.
- Pipeline (latency 4 cycles, input valid at edge N -> conv_data_valid at edge N+4; throughput 1/cycle; valid propagates unchanged when the input valid is 0):
  - S1: p_i zero-extended to signed PIX_W+1; prod_i = p_i * k_i, width PIX_W+COEF_W+1.
  - S2: three row sums, each PIX_W+COEF_W+3 bits signed.
  - S3: total SUM_W = PIX_W+COEF_W+5 bits signed. No overflow is possible at any stage.
  - S4: normalise: arithmetic right shift by the carried shift (rounding per the optional feature). Then apply the carried mode:
    - abs=0: negative -> 0; > 2^PIX_W-1 -> 2^PIX_W-1.
    - abs=1: take |x|, then clamp to 2^PIX_W-1.
    - sat_flag = 1 when either clamp fired; it is qualified by conv_data_valid and forced to 0 when valid is 0.
- conv_data holds its last value when valid is 0.
- No handshake on the input side; the upstream block guarantees one window per valid.

Optional Feature:
- Macro CONV_ROUND_EN.
  - Defined: S4 adds 2^(shift-1) before the arithmetic shift when shift > 0 (round half up toward +inf). The adder is 1 bit wider so it cannot overflow.
  - Undefined: plain arithmetic shift (floor).
- Latency is 4 in both builds.

Test Plan:
- Post-reset passthrough: no config; stream taps all 0 except tap4 = 0,1,128,255 on consecutive cycles -> conv_data 0,1,128,255 at cycles N+4..N+7, sat_flag 0.
- Box blur: load all taps = 1, shift = 3, abs = 0, commit; window of all 200 -> 1800>>3 = 225. With CONV_ROUND_EN, all 7 -> 63>>3 gives 8 (rounded) vs 7 (floor).
- Sobel-X abs: taps -1,0,1,-2,0,2,-1,0,1, shift 0, abs=1; columns 0/1/2 = 10/x/50 -> |160| = 160. Mirrored window -> 160; mode abs=0 on the mirrored window -> 0.
- Saturation: taps all 2, shift 0, all pixels 255 -> conv_data 255, sat_flag 1. Negative kernel with abs=0 -> 0, sat_flag 1.
- Commit mid-stream: continuous valid stream; commit a new kernel at edge M -> beats accepted up to edge M use the old kernel, beats from M+1 use the new one. Same-cycle coef_we+commit on tap 4 is honoured.
- Reset mid-stream: assert rst for 1 cycle with 3 beats in flight -> no conv_data_valid for those beats, kernel back to identity, and the next beat passes through 4 cycles later.

Source files
------------

// File: rtl/conv3x3_prog.sv
// rtl/conv3x3_prog.sv - programmable 3x3 convolution, 4-cycle latency, 1 pixel/cycle.
// Optional rounding normalisation enabled by defining CONV_ROUND_EN.
module conv3x3_prog #(
  parameter int PIX_W   = 8,
  parameter int COEF_W  = 8,
  parameter int SHIFT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [9*PIX_W-1:0]   pixel_data,
  input  logic                 pixel_data_valid,
  input  logic                 coef_we,
  input  logic [3:0]           coef_addr,
  input  logic [COEF_W-1:0]    coef_data,
  input  logic [SHIFT_W-1:0]   cfg_shift,
  input  logic                 cfg_abs,
  input  logic                 coef_commit,
  output logic [PIX_W-1:0]     conv_data,
  output logic                 conv_data_valid,
  output logic                 sat_flag
);

  localparam int PROD_W = PIX_W + COEF_W + 1;
  localparam int ROW_W  = PIX_W + COEF_W + 3;
  localparam int SUM_W  = PIX_W + COEF_W + 5;
  localparam int NORM_W = SUM_W + 1;

  localparam logic [COEF_W-1:0]        COEF_ONE = {{(COEF_W-1){1'b0}}, 1'b1};
  localparam logic signed [NORM_W-1:0] PIX_MAX  = NORM_W'((1 << PIX_W) - 1);

  // coefficient banks
  logic [COEF_W-1:0]  r_shadow [9];
  logic [COEF_W-1:0]  r_active [9];
  logic [SHIFT_W-1:0] r_act_shift;
  logic               r_act_abs;
  logic [8:0]         w_wr_hit;

  always_comb begin
    w_wr_hit = '0;
    for (int i = 0; i < 9; i++) begin
      w_wr_hit[i] = coef_we && (coef_addr == 4'(i));
    end
  end

  // A write in the commit cycle bypasses the shadow so it lands in the active bank too.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) begin
        r_shadow[i] <= (i == 4) ? COEF_ONE : '0;
        r_active[i] <= (i == 4) ? COEF_ONE : '0;
      end
      r_act_shift <= '0;
      r_act_abs   <= 1'b0;
    end else begin
      for (int i = 0; i < 9; i++) begin
        if (w_wr_hit[i]) r_shadow[i] <= coef_data;
        if (coef_commit) r_active[i] <= w_wr_hit[i] ? coef_data : r_shadow[i];
      end
      if (coef_commit) begin
        r_act_shift <= cfg_shift;
        r_act_abs   <= cfg_abs;
      end
    end
  end

  // S1: per-tap signed products
  logic signed [PROD_W-1:0] w_prod [9];
  logic signed [PROD_W-1:0] r_prod [9];
  logic                     r_v1, r_ab1;
  logic [SHIFT_W-1:0]       r_sh1;

  always_comb begin
    for (int i = 0; i < 9; i++) begin
      w_prod[i] = $signed({{(PROD_W-PIX_W){1'b0}}, pixel_data[i*PIX_W +: PIX_W]})
                * $signed({{(PROD_W-COEF_W){r_active[i][COEF_W-1]}}, r_active[i]});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) r_prod[i] <= '0;
      r_v1  <= 1'b0;
      r_sh1 <= '0;
      r_ab1 <= 1'b0;
    end else begin
      for (int i = 0; i < 9; i++) r_prod[i] <= w_prod[i];
      r_v1  <= pixel_data_valid;
      r_sh1 <= r_act_shift;
      r_ab1 <= r_act_abs;
    end
  end

  // S2: row sums
  logic signed [ROW_W-1:0] r_row [3];
  logic                    r_v2, r_ab2;
  logic [SHIFT_W-1:0]      r_sh2;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 3; r++) r_row[r] <= '0;
      r_v2  <= 1'b0;
      r_sh2 <= '0;
      r_ab2 <= 1'b0;
    end else begin
      for (int r = 0; r < 3; r++) begin
        r_row[r] <= ROW_W'(r_prod[3*r]) + ROW_W'(r_prod[3*r+1]) + ROW_W'(r_prod[3*r+2]);
      end
      r_v2  <= r_v1;
      r_sh2 <= r_sh1;
      r_ab2 <= r_ab1;
    end
  end

  // S3: window total
  logic signed [SUM_W-1:0] r_sum;
  logic                    r_v3, r_ab3;
  logic [SHIFT_W-1:0]      r_sh3;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum <= '0;
      r_v3  <= 1'b0;
      r_sh3 <= '0;
      r_ab3 <= 1'b0;
    end else begin
      r_sum <= SUM_W'(r_row[0]) + SUM_W'(r_row[1]) + SUM_W'(r_row[2]);
      r_v3  <= r_v2;
      r_sh3 <= r_sh2;
      r_ab3 <= r_ab2;
    end
  end

  // S4a: normalise by the shift that travelled with this beat
  logic signed [NORM_W-1:0] w_norm;
`ifdef CONV_ROUND_EN
  logic [NORM_W-1:0]        w_bias;
  logic signed [NORM_W-1:0] w_rnd;

  always_comb begin
    w_bias = ({{(NORM_W-1){1'b0}}, 1'b1} << r_sh3) >> 1;
    w_rnd  = NORM_W'(r_sum) + $signed(w_bias);
    w_norm = w_rnd >>> r_sh3;
  end
`else
  always_comb begin
    w_norm = NORM_W'(r_sum) >>> r_sh3;
  end
`endif

  logic signed [NORM_W-1:0] r_norm;
  logic                     r_v4, r_ab4;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_norm <= '0;
      r_v4   <= 1'b0;
      r_ab4  <= 1'b0;
    end else begin
      r_norm <= w_norm;
      r_v4   <= r_v3;
      r_ab4  <= r_ab3;
    end
  end

  // S4b: clamp or absolute-value mode, then register the output pixel
  logic                     w_neg;
  logic signed [NORM_W-1:0] w_mag;
  logic [PIX_W-1:0]         w_clip;
  logic                     w_sat;

  always_comb begin
    w_neg  = r_norm[NORM_W-1];
    w_mag  = w_neg ? -r_norm : r_norm;
    w_clip = w_mag[PIX_W-1:0];
    w_sat  = 1'b0;
    if (r_ab4) begin
      if (w_mag > PIX_MAX) begin
        w_clip = '1;
        w_sat  = 1'b1;
      end
    end else if (w_neg) begin
      w_clip = '0;
      w_sat  = 1'b1;
    end else if (r_norm > PIX_MAX) begin
      w_clip = '1;
      w_sat  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      conv_data       <= '0;
      conv_data_valid <= 1'b0;
      sat_flag        <= 1'b0;
    end else begin
      conv_data_valid <= r_v4;
      sat_flag        <= r_v4 & w_sat;
      if (r_v4) conv_data <= w_clip;
    end
  end

endmodule
